// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: operand width, canonical quiet NaN and the
// accumulation sequencer FSM state encoding.
package fp16_pkg;

  localparam int unsigned FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OUT   = 3'd5
  } acc_state_e;

endpackage

// File: rtl/fp16_acc_sequencer.sv
// Sums fp16 operand vectors by driving an external adder's start/valid/clear
// handshake. Optional adder watchdog enabled by FP16_ACC_TIMEOUT_EN.
module fp16_acc_sequencer
  import fp16_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              i_in_valid,
  input  logic [FP16_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_in_ready,
  output logic              o_add_start,
  output logic [FP16_W-1:0] o_add_a,
  output logic [FP16_W-1:0] o_add_b,
  output logic              o_add_clear,
  input  logic              i_add_valid,
  input  logic [FP16_W-1:0] i_add_result,
  output logic              o_out_valid,
  output logic [FP16_W-1:0] o_out_data,
  output logic [CNT_W-1:0]  o_out_count,
`ifdef FP16_ACC_TIMEOUT_EN
  input  logic              i_out_ready,
  output logic              o_err
`else
  input  logic              i_out_ready
`endif
);

  acc_state_e        r_state;
  acc_state_e        w_state_nxt;
  logic [FP16_W-1:0] r_acc;
  logic [FP16_W-1:0] r_opnd;
  logic              r_last_q;
  logic [CNT_W-1:0]  r_cnt;
  logic [FP16_W-1:0] w_acc_nxt;
  logic [FP16_W-1:0] w_opnd_nxt;
  logic              w_last_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;

  logic              r_in_ready;
  logic              r_add_start;
  logic              r_add_clear;
  logic              r_out_valid;
  logic [FP16_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_out_count;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next datapath values
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_opnd_nxt  = r_opnd;
    w_last_nxt  = r_last_q;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid && r_in_ready) begin
          w_acc_nxt   = i_in_data;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = i_in_last ? ST_OUT : ST_ACC;
        end
      end
      ST_ACC: begin
        if (i_in_valid && r_in_ready) begin
          w_opnd_nxt  = i_in_data;
          w_last_nxt  = i_in_last;
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_add_valid) begin
          w_acc_nxt   = i_add_result;
          w_state_nxt = ST_CLEAR;
        end else if (w_timeout) begin
          w_acc_nxt   = FP16_QNAN;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: w_state_nxt = r_last_q ? ST_OUT : ST_ACC;
      ST_OUT: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and outputs, registered from the next state
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_acc       <= '0;
      r_opnd      <= '0;
      r_last_q    <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_add_start <= 1'b0;
      r_add_clear <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_opnd      <= w_opnd_nxt;
      r_last_q    <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ACC);
      r_add_start <= (w_state_nxt == ST_START);
      r_add_clear <= (w_state_nxt == ST_CLEAR);
      r_out_valid <= (w_state_nxt == ST_OUT);
      // Capture the result once on entry so it stays frozen while stalled
      if ((w_state_nxt == ST_OUT) && (r_state != ST_OUT)) begin
        r_out_data  <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
      end
    end
  end

`ifdef FP16_ACC_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  assign w_timeout = (r_state == ST_WAIT) && !i_add_valid &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts consecutive WAIT cycles; err is sticky until reset
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wd_cnt <= ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) ?
                  r_wd_cnt + WD_W'(1) : '0;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  logic [31:0] w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = 32'(TIMEOUT_CYCLES);
`endif

  assign o_in_ready  = r_in_ready;
  assign o_add_start = r_add_start;
  assign o_add_a     = r_acc;
  assign o_add_b     = r_opnd;
  assign o_add_clear = r_add_clear;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_count = r_out_count;

endmodule

// File: doc/fp16_acc_sequencer.md
# fp16_acc_sequencer

Initiator for the fp16 adder's start/valid/clear handshake. Accepts a stream of fp16 operands over valid/ready, delimited by `in_last`, and sums each vector by running one adder transaction per operand after the first. Sits between an NPU operand buffer and an externally instantiated fp16 adder. Returns one fp16 sum and an operand count per vector.

## Interface
- `CNT_W`, 8: width of the operand counter and `out_count`.
- `TIMEOUT_CYCLES`, 64: adder watchdog limit; used only with `FP16_ACC_TIMEOUT_EN`.
- `clk` input 1: clock.
- `reset_b` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand available.
- `in_data` input 16: fp16 operand.
- `in_last` input 1: operand is the last of its vector.
- `in_ready` output 1: operand accepted when `in_valid & in_ready`.
- `add_start` output 1: one-cycle start pulse to the adder.
- `add_a` output 16: accumulator operand.
- `add_b` output 16: new operand.
- `add_clear` output 1: one-cycle clear pulse to the adder.
- `add_valid` input 1: adder result valid, level, held until clear.
- `add_result` input 16: adder sum.
- `out_valid` output 1: sum available.
- `out_data` output 16: vector sum.
- `out_count` output CNT_W: operands in the vector, saturating at all-ones.
- `out_ready` input 1: sum consumed when `out_valid & out_ready`.
- `err` output 1: watchdog fired; present only with `FP16_ACC_TIMEOUT_EN`.

## Operation
- Registers:
  - `acc[15:0]` holds the running sum.
  - `opnd[15:0]` holds the current operand.
  - `last_q` records whether the current operand ended the vector.
  - `cnt[CNT_W-1:0]` counts accepted operands.
- FSM states: IDLE, ACC, START, WAIT, CLEAR, OUT.
- IDLE:
  - `in_ready=1`.
  - On accept: `acc<=in_data`, `cnt<=1`.
  - If `in_last`, go to OUT; otherwise go to ACC. This first operand does not use the adder.
- ACC:
  - `in_ready=1`.
  - On accept: `opnd<=in_data`, `last_q<=in_last`, `cnt<=cnt+1` (saturating), then go to START.
- START: `add_start=1` for exactly one cycle, then go to WAIT.
- WAIT:
  - When `add_valid=1`: `acc<=add_result`, go to CLEAR.
- CLEAR:
  - `add_clear=1` for exactly one cycle.
  - Go to OUT if `last_q`, otherwise go to ACC.
- OUT:
  - `out_valid=1`; `out_data=acc`; `out_count=cnt`.
  - On `out_ready`, go to IDLE.
- `add_a=acc` and `add_b=opnd` are driven from registers and stay stable from START through CLEAR. The adder samples its inputs combinationally throughout its transaction.
- `in_ready=0` in START, WAIT, CLEAR and OUT. There is at most one adder transaction in flight.
- Zero, cancellation and sign are handled by the adder. This block never inspects fp16 fields.
- Simultaneous `in_valid` and `out_ready` in OUT: only the output transfer completes; the operand is accepted next cycle in IDLE.

## Timing
- Reset values: `in_ready=0` during reset and 1 in the first cycle after release. `add_start=0`, `add_clear=0`, `out_valid=0`, `out_data=0`, `out_count=0`, `err=0`, `add_a=0`, `add_b=0`. State is IDLE.
- Per extra operand: accept (ACC) → START (1) → WAIT (adder latency L≥2) → CLEAR (1). Total is L+3 cycles before the next accept.
- Single-operand vector: `out_valid` rises the cycle after accept.
- `out_data` and `out_count` are held while `out_valid=1 & out_ready=0`.
- Reset assertion mid-transaction, in any state, returns all outputs to their reset values immediately. The adder shares `reset_b`, so no clear is issued.
- `add_valid` seen in a state other than WAIT is ignored.

## Configuration
- Macro `FP16_ACC_TIMEOUT_EN`.
- When defined:
  - A watchdog counter runs in WAIT.
  - If WAIT lasts `TIMEOUT_CYCLES` cycles without `add_valid`: `acc<=16'h7E00` (qNaN), `err<=1` (sticky until reset), go to CLEAR.
  - After that, the remaining operands of the vector are still accepted and summed, giving a NaN result.
- When undefined: no `err` port and no counter; WAIT is held indefinitely.

## Structure
- Shared package `fp16_pkg`:
  - FSM state enum.
  - `FP16_QNAN = 16'h7E00`.
  - `FP16_W = 16`.
- No sub-module; the parent instantiates the adder beside this block.

## Test plan
- Vector 0x3C00, 0x4000, 0x4200 (last), with an adder model of latency 5: `out_data=0x4600`, `out_count=3`. Exactly two `add_start` pulses and two `add_clear` pulses.
- Single operand 0x4500 with `in_last`: `out_data=0x4500`, `out_count=1`, zero `add_start` pulses, `out_valid` one cycle after accept.
- 0x4000, 0xC000 (last): the adder returns 0x0000, so `out_data=0x0000`, `out_count=2`.
- `out_ready` held low for 5 cycles in OUT: `out_data` is stable, `in_ready=0`. On release, IDLE is reached next cycle.
- With `FP16_ACC_TIMEOUT_EN` and the adder stuck: after 64 cycles in WAIT, `add_clear` pulses, `err=1`, and `out_data=0x7E00`.
- `reset_b` pulsed low in WAIT: all outputs return to their reset values; a new vector 0x3C00, 0x3C00 then yields 0x4000.
